bram_ctrl_init: RTL

//  Parametrised simple-dual-port block-RAM controller for iCE40 designs: one write port, one read port.

---
 rtl/bram_ctrl_init_if.sv | 27 ++
 rtl/bram_ctrl_init.sv | 98 +++++++++
 2 files changed

// File: rtl/bram_ctrl_init_if.sv
// rtl/bram_ctrl_init_if.sv - request/response bundle between front-end logic and the BRAM controller
interface bram_ctrl_init_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              clr_req;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              init_done;

  modport master (
    output clr_req, wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_ack, rd_data, rd_valid, busy, init_done
  );

  modport slave (
    input  clr_req, wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_ack, rd_data, rd_valid, busy, init_done
  );
endinterface

// File: rtl/bram_ctrl_init.sv
// rtl/bram_ctrl_init.sv - simple-dual-port BRAM controller with init/clear sequencer
module bram_ctrl_init #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                RD_LAT   = 1,
  parameter int                WR_FIRST = 1
) (
  input logic              CLK,
  input logic              RST,
  bram_ctrl_init_if.slave  bus
);
  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic              rd_acc;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;
  logic              p_valid;
  logic [DATA_W-1:0] p_data;

  assign rd_acc = (state == RUN) && bus.rd_req;
  assign wr_en  = (state == RUN) && bus.wr_req;

  // Same-address collision: bypass the incoming write data when write-first is selected.
  always_comb begin
    rd_word = mem[bus.rd_addr];
    if ((WR_FIRST != 0) && wr_en && (bus.wr_addr == bus.rd_addr))
      rd_word = bus.wr_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= INIT;
      init_ptr      <= '0;
      bus.busy      <= 1'b1;
      bus.init_done <= 1'b0;
      bus.wr_ack    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          bus.wr_ack <= 1'b0;
          if (init_ptr == {ADDR_W{1'b1}}) begin
            state         <= RUN;
            bus.busy      <= 1'b0;
            bus.init_done <= 1'b1;
          end else begin
            init_ptr <= init_ptr + 1'b1;
          end
        end
        RUN: begin
          bus.wr_ack <= bus.wr_req;
          if (bus.clr_req) begin
            state    <= INIT;
            init_ptr <= '0;
            bus.busy <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == INIT)
        mem[init_ptr] <= INIT_VAL;
      else if (bus.wr_req)
        mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read pipeline keeps running through INIT so reads accepted before a clear still complete.
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_valid      <= 1'b0;
      p_data       <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      p_valid <= rd_acc;
      if (rd_acc)
        p_data <= rd_word;
      if (RD_LAT == 1) begin
        bus.rd_valid <= rd_acc;
        if (rd_acc)
          bus.rd_data <= rd_word;
      end else begin
        bus.rd_valid <= p_valid;
        if (p_valid)
          bus.rd_data <= p_data;
      end
    end
  end
endmodule
